// File: rtl/floo_look_ahead_route_stage_if.sv
// Lane bundle for the look-ahead route stage: header request side (in_*) and
// routed result side (out_*), one bit/field per input port.
interface floo_look_ahead_route_stage_if #(
  parameter int unsigned NumPorts = 5,
  parameter int unsigned XWidth   = 3,
  parameter int unsigned YWidth   = 3,
  parameter int unsigned DirWidth = 3
) ();
  logic [NumPorts-1:0]          in_vld;
  logic [NumPorts-1:0]          in_rdy;
  logic [NumPorts*XWidth-1:0]   dst_x;
  logic [NumPorts*YWidth-1:0]   dst_y;
  logic [NumPorts*DirWidth-1:0] dir;
  logic [NumPorts-1:0]          out_vld;
  logic [NumPorts-1:0]          out_rdy;
  logic [NumPorts*DirWidth-1:0] out_dir;
  logic [NumPorts*DirWidth-1:0] la_dir;
  logic [NumPorts-1:0]          err;

  modport master (
    output in_vld, dst_x, dst_y, dir, out_rdy,
    input  in_rdy, out_vld, out_dir, la_dir, err
  );

  modport slave (
    input  in_vld, dst_x, dst_y, dir, out_rdy,
    output in_rdy, out_vld, out_dir, la_dir, err
  );
endinterface

// File: rtl/floo_look_ahead_route_stage.sv
// Per-port look-ahead route stage: next-hop coordinate + XY/YX route at that hop,
// 1-cycle latency through a 2-entry FIFO; ready depends only on registered occupancy.
module floo_look_ahead_route_stage #(
  parameter int unsigned NumPorts  = 5,
  parameter int unsigned XWidth    = 3,
  parameter int unsigned YWidth    = 3,
  parameter int unsigned NumX      = 4,
  parameter int unsigned NumY      = 4,
  parameter int unsigned RouteAlgo = 0,
  parameter int unsigned DirWidth  = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [XWidth+YWidth-1:0]   xy_id_i,
  input  logic                       clr_err_i,
  output logic [NumPorts-1:0]        err_sticky_o,
  floo_look_ahead_route_stage_if.slave lane_io
);

  typedef logic [DirWidth-1:0] dir_t;
  typedef logic [XWidth:0]     xw_t;
  typedef logic [YWidth:0]     yw_t;

  typedef struct packed {
    dir_t dir;
    dir_t la;
    logic err;
  } entry_t;

  localparam dir_t DirN  = dir_t'(0);
  localparam dir_t DirE  = dir_t'(1);
  localparam dir_t DirS  = dir_t'(2);
  localparam dir_t DirW  = dir_t'(3);
  localparam dir_t DirEj = dir_t'(4);
  localparam xw_t  XOne  = xw_t'(1);
  localparam yw_t  YOne  = yw_t'(1);
  localparam xw_t  XLim  = xw_t'(NumX);
  localparam yw_t  YLim  = yw_t'(NumY);

  // One extra bit on the coordinates so a step off either mesh edge lands >= limit.
  function automatic entry_t next_hop(input logic [XWidth-1:0] x, input logic [YWidth-1:0] y,
                                      input logic [XWidth-1:0] dx, input logic [YWidth-1:0] dy,
                                      input dir_t d);
    xw_t    nx, tx;
    yw_t    ny, ty;
    logic   oob;
    entry_t e;
    nx = {1'b0, x};
    ny = {1'b0, y};
    tx = {1'b0, dx};
    ty = {1'b0, dy};
    case (d)
      DirN:    ny = ny + YOne;
      DirE:    nx = nx + XOne;
      DirS:    ny = ny - YOne;
      DirW:    nx = nx - XOne;
      default: ;
    endcase
    oob   = (nx >= XLim) | (ny >= YLim);
    e.dir = d;
    e.err = (d > DirEj) | oob;
    e.la  = DirEj;
    if (!e.err && (d != DirEj)) begin
      if (RouteAlgo == 0) begin
        if (tx > nx)      e.la = DirE;
        else if (tx < nx) e.la = DirW;
        else if (ty > ny) e.la = DirN;
        else if (ty < ny) e.la = DirS;
      end else begin
        if (ty > ny)      e.la = DirN;
        else if (ty < ny) e.la = DirS;
        else if (tx > nx) e.la = DirE;
        else if (tx < nx) e.la = DirW;
      end
    end
    return e;
  endfunction

  logic [NumPorts-1:0] rdy_vec;
  logic [NumPorts-1:0] vld_vec;
  logic [NumPorts-1:0] err_vec;
  logic [NumPorts-1:0] sticky_vec;
  dir_t                dir_arr [NumPorts];
  dir_t                la_arr  [NumPorts];

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic [1:0] cnt_q, cnt_d;
    logic       wr_q, rd_q;
    logic       sticky_q, sticky_d;
    logic       push, pop;
    entry_t     mem_q [2];
    entry_t     ent;
    entry_t     head;

    assign rdy_vec[p] = (cnt_q != 2'd2) & ~rst_i;
    assign vld_vec[p] = (cnt_q != 2'd0);
    assign push       = lane_io.in_vld[p] & rdy_vec[p];
    assign pop        = vld_vec[p] & lane_io.out_rdy[p];
    assign ent        = next_hop(xy_id_i[XWidth-1:0], xy_id_i[XWidth+YWidth-1:XWidth],
                                 lane_io.dst_x[p*XWidth +: XWidth],
                                 lane_io.dst_y[p*YWidth +: YWidth],
                                 lane_io.dir[p*DirWidth +: DirWidth]);
    assign head       = mem_q[rd_q];

    always_comb begin
      cnt_d    = cnt_q + 2'(push) - 2'(pop);
      sticky_d = sticky_q;
      // A new error push beats a simultaneous clear.
      if (push && ent.err) sticky_d = 1'b1;
      else if (clr_err_i)  sticky_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q    <= 2'd0;
        wr_q     <= 1'b0;
        rd_q     <= 1'b0;
        sticky_q <= 1'b0;
        mem_q[0] <= '0;
        mem_q[1] <= '0;
      end else begin
        cnt_q    <= cnt_d;
        sticky_q <= sticky_d;
        if (push) begin
          mem_q[wr_q] <= ent;
          wr_q        <= ~wr_q;
        end
        if (pop) rd_q <= ~rd_q;
      end
    end

    // Empty FIFO presents zeros rather than a stale head.
    assign dir_arr[p]    = vld_vec[p] ? head.dir : '0;
    assign la_arr[p]     = vld_vec[p] ? head.la  : '0;
    assign err_vec[p]    = vld_vec[p] & head.err;
    assign sticky_vec[p] = sticky_q;
  end

  assign lane_io.in_rdy  = rdy_vec;
  assign lane_io.out_vld = vld_vec;
  assign lane_io.err     = err_vec;
  assign err_sticky_o    = sticky_vec;

  always_comb begin
    lane_io.out_dir = '0;
    lane_io.la_dir  = '0;
    for (int p = 0; p < NumPorts; p++) begin
      lane_io.out_dir[p*DirWidth +: DirWidth] = dir_arr[p];
      lane_io.la_dir[p*DirWidth +: DirWidth]  = la_arr[p];
    end
  end

endmodule

// File: doc/floo_look_ahead_route_stage.md
Name: floo_look_ahead_route_stage

Overview:
- Registered, multi-port look-ahead routing stage for the VC router input side.
- For each input port it accepts a head-flit header and derives the next-hop coordinate from the local router id and the flit's current look-ahead direction.
- It then computes the direction the flit must take at that next hop, using XY or YX dimension-order routing.
- Results are buffered in a per-port 2-entry skid FIFO with valid/ready handshakes, and out-of-mesh and illegal-direction conditions are flagged.

Parameters:
- NumPorts, 5, number of independent input ports (lanes).
- XWidth, 3, bit width of the x coordinate.
- YWidth, 3, bit width of the y coordinate.
- NumX, 4, mesh size in x; legal x range is 0..NumX-1.
- NumY, 4, mesh size in y; legal y range is 0..NumY-1.
- RouteAlgo, 0, dimension order: 0 = XY (x first), 1 = YX (y first).
- DirWidth, 3, direction code width. Encoding: N=0, E=1, S=2, W=3, Eject=4; codes 5..7 are illegal.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- xy_id_i, in, XWidth+YWidth, local router coordinate {y,x}; quasi-static.
- valid_i, in, NumPorts, header valid per port.
- ready_o, out, NumPorts, header accepted per port.
- dst_x_i, in, NumPorts*XWidth, destination x per port.
- dst_y_i, in, NumPorts*YWidth, destination y per port.
- dir_i, in, NumPorts*DirWidth, current look-ahead direction, i.e. this router's output.
- valid_o, out, NumPorts, result valid per port.
- ready_i, in, NumPorts, downstream consume per port.
- dir_o, out, NumPorts*DirWidth, dir_i of the head entry, passed through.
- la_dir_o, out, NumPorts*DirWidth, computed next-hop direction.
- err_o, out, NumPorts, error flag of the head entry.
- err_sticky_o, out, NumPorts, sticky error per port.
- clr_err_i, in, 1, clears all sticky errors.

Behaviour:
- Clock and reset:
  - One clock, clk_i. Reset rst_i is synchronous and active-high.
  - All state is cleared at the first rising edge with rst_i=1.
- Reset values:
  - valid_o=0, err_sticky_o=0, FIFO count=0.
  - dir_o, la_dir_o and err_o read 0.
  - ready_o=0 while rst_i=1; ready_o=1 on the first cycle after deassertion.
  - Reset mid-operation drops all buffered entries without emitting them.
- Ports are fully independent. There is no cross-port arbitration.
- Handshake:
  - Push on valid_i & ready_o. Pop on valid_o & ready_i.
  - ready_o = (count<2) & !rst_i, driven from registered count only. There is no combinational path from ready_i.
  - valid_o = (count!=0).
  - Payload must be held stable while valid_i & !ready_o.
- Latency: 1 cycle from push to valid_o; the entry is visible the cycle after acceptance.
  - Throughput is 1 flit/cycle/port.
  - count=1 with push and pop in the same cycle leaves count=1, and the new entry becomes head next cycle.
  - count=2: no push is possible; a pop returns count to 1 and ready_o rises the next cycle.
- FIFO order: in-order. Pointers wrap modulo 2.
- Next-hop computation, combinational on push, result stored:
  - Start from nx=x, ny=y.
  - N: ny=y+1. S: ny=y-1. E: nx=x+1. W: nx=x-1. Eject: next hop is the local router.
  - Arithmetic uses XWidth+1 / YWidth+1 bits so that underflow (-1) and overflow (>=NumX or >=NumY) are detectable. Nothing wraps.
- Look-ahead routing at (nx,ny):
  - XY: dst_x>nx gives E; dst_x<nx gives W; otherwise dst_y>ny gives N; dst_y<ny gives S; otherwise Eject.
  - YX: the same rules with y compared first.
  - dir_i=Eject gives la=Eject.
- Errors:
  - An entry's err bit is set if dir_i is illegal (5..7) or (nx,ny) is out of mesh.
  - When err is set, la is forced to Eject and dir_o still passes dir_i through.
  - err_sticky_o[p] is set in the cycle after a push with err.
  - clr_err_i clears the sticky bits. If clr_err_i coincides with a new error push, the set wins.

Test Plan:
- Reset, then push on port 0: xy=(1,1), dir=E, dst=(3,0), XY mode → next cycle valid_o[0]=1, dir_o=E, la_dir_o=E, err_o=0.
- Same stimulus with RouteAlgo=1 (YX) → la_dir_o=S. Then dst=(2,1) with dir=E → la_dir_o=Eject.
- Edge detection: xy=(0,0), dir=W → err_o=1, la_dir_o=Eject, err_sticky_o[0]=1 the following cycle. Then clr_err_i=1 → sticky returns to 0. Then dir_i=6 → err_o=1.
- Backpressure: hold ready_i=0 and push 3 flits → ready_o drops after 2 accepted; release ready_i → flits emerge in order; ready_o returns 1 cycle after the first pop.
- Streaming: valid_i and ready_i held at 1 for 20 cycles on all 5 ports with distinct headers → 20 outputs per port, in order, no bubbles, no cross-port mixing.
- Assert rst_i while 2 entries are buffered → next cycle valid_o=0, ready_o=0; after deassertion ready_o=1, and stale entries are never seen.
